if_ecc_stage: RTL and testbench
===============================

IF_ECC_STAGE -- requirements
Module: if_ecc_stage

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL take parameter CE_CNT_W, default 16: width of the corrected-error counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall_i  input  1  hold PC and the IF/ID register this cycle.
REQ-006 flush_i  input  1  redirect: load PC from pc_target_i and squash the current fetch.
REQ-007 pc_target_i  input  32  redirect target, word-aligned.
REQ-008 imem_addr_o  output  32  instruction memory byte address; combinationally equal to the PC register.
REQ-009 imem_rdata_i  input  39  SECDED-encoded word for imem_addr_o, valid the same cycle.
REQ-010 instr_o  output  32  registered, corrected instruction (IF/ID).
REQ-011 op_o  output  7  instr_o[6:0]; feeds the main decoder Op input.
REQ-012 pc_o  output  32  registered PC of instr_o.
REQ-013 valid_o  output  1  instr_o, op_o and pc_o hold a real instruction.
REQ-014 corrected_o  output  1  the instruction in IF/ID had a single-bit error corrected.
REQ-015 uncorrectable_o  output  1  sticky: a double error was fetched and the stage is halted.
REQ-016 ce_count_o  output  CE_CNT_W  saturating count of corrected fetches.

Function
REQ-017 Code layout SHALL be: bit 0 = overall even parity over bits 38:1; bits 1,2,4,8,16,32 = Hamming check bits; the remaining 32 positions, ascending, SHALL carry instr[0]..instr[31].
REQ-018 Syndrome SHALL be the XOR of the position indices (1..38) of all set bits; parity error SHALL mean XOR of bits 38:0 = 1.
REQ-019 Classification SHALL be: syndrome 0 and no parity error = clean; syndrome 0 and parity error = corrected (bit 0 only, data unchanged); syndrome 1..38 and parity error = corrected (flip that position); syndrome nonzero and no parity error, or syndrome >38, = uncorrectable.
REQ-020 The FSM SHALL have states RUN and HALT; reset SHALL enter RUN.
REQ-021 In RUN with flush_i=1 (flush wins over stall_i): PC <= pc_target_i, valid_o <= 0, corrected_o <= 0, and the current word's classification SHALL be ignored.
REQ-022 In RUN with flush_i=0 and stall_i=1: PC, instr_o, pc_o, valid_o, corrected_o and the counter SHALL hold.
REQ-023 In RUN with neither asserted and the word not uncorrectable: instr_o <= corrected data, pc_o <= PC, valid_o <= 1, corrected_o <= corrected flag, PC <= PC+4 (mod 2^32 wrap).
REQ-024 In RUN with neither asserted and the word uncorrectable: valid_o <= 0, corrected_o <= 0, uncorrectable_o <= 1, PC SHALL hold, next state HALT.
REQ-025 In HALT: valid_o and corrected_o SHALL be 0, PC and counter SHALL hold, and flush_i and stall_i SHALL be ignored; only rst SHALL exit.
REQ-026 ce_count_o SHALL increment by 1 on each RUN capture with the corrected flag set (REQ-023) and SHALL saturate at all-ones.
REQ-027 Fetch-to-IF/ID latency SHALL be one cycle; there SHALL be no combinational path from imem_rdata_i to any output.

Reset
REQ-028 On rst, asynchronously: PC = RESET_PC, instr_o = 32'h0000_0013 (NOP), pc_o = 0, valid_o = 0, corrected_o = 0, uncorrectable_o = 0, ce_count_o = 0, state = RUN.
REQ-029 Reset asserted mid-stall, mid-flush or in HALT SHALL produce exactly the REQ-028 state; the first fetch after deassertion SHALL be from RESET_PC.

Structure
REQ-030 A shared package SHALL hold the code widths (39/32/6), check-bit position constants, the NOP constant and the RUN/HALT state enum.
REQ-031 SECDED decoding SHALL be a combinational sub-module secded_39_32_dec (word in; data, corrected, uncorrectable out), reusable by the data-memory path.

Verification
REQ-032 Clean encode of 32'h0050_0093 at PC 0 -> next cycle: instr_o=32'h0050_0093, op_o=7'h13, pc_o=0, valid_o=1, corrected_o=0; PC=4.
REQ-033 The same word with position 3 (instr[0]) flipped -> instr_o=32'h0050_0093, corrected_o=1, ce_count_o=1; bit 0 alone flipped -> same data, corrected_o=1.
REQ-034 Positions 3 and 5 flipped -> valid_o=0, uncorrectable_o=1, PC held, HALT; later flush_i with target 32'h100 -> no change until rst.
REQ-035 flush_i and stall_i together, pc_target_i=32'h100, double-error word present -> valid_o=0, PC=32'h100, uncorrectable_o stays 0.
REQ-036 stall_i held 3 cycles -> instr_o, pc_o and PC unchanged; then PC=32'hFFFF_FFFC clean fetch -> PC wraps to 0.
REQ-037 With CE_CNT_W=4, 17 single-error fetches -> ce_count_o=4'hF; rst asserted mid-HALT -> REQ-028 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_ecc_stage_pkg.sv
// Shared SECDED(39,32) code layout, fetch-stage bundle and FSM states.
// Position p of the code word covers check bit j when bit j of p is set.
package if_ecc_stage_pkg;

  localparam int CODE_W = 39;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 6;

  localparam int CHK_POS [CHK_W] = '{1, 2, 4, 8, 16, 32};

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [31:0]       pc;
    logic              valid;
    logic              corrected;
  } if_id_t;

  function automatic logic [CODE_W-1:0] syn_mask(input int j);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (((p >> j) & 1) == 1) m = m | (CODE_W'(1) << p);
    end
    return m;
  endfunction

  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_39_32_dec.sv
// Combinational SECDED(39,32) decoder: syndrome, overall parity,
// single-bit correction and double-error detection.
module secded_39_32_dec
  import if_ecc_stage_pkg::*;
(
  input  logic [CODE_W-1:0] word_i,
  output logic [DATA_W-1:0] data_o,
  output logic              corrected_o,
  output logic              uncorrectable_o
);

  logic [CHK_W-1:0]  syn;
  logic              perr;
  logic              fix;
  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] fixed;

  for (genvar j = 0; j < CHK_W; j++) begin : g_syn
    assign syn[j] = ^(word_i & syn_mask(j));
  end

  assign perr = ^word_i;

  always_comb begin
    corrected_o     = 1'b0;
    uncorrectable_o = 1'b0;
    fix             = 1'b0;
    unique case (1'b1)
      (syn == '0) && !perr: corrected_o = 1'b0;
      (syn == '0) && perr:  corrected_o = 1'b1;
      (syn != '0) && perr && (syn <= 6'(CODE_W - 1)): begin
        corrected_o = 1'b1;
        fix         = 1'b1;
      end
      default: uncorrectable_o = 1'b1;
    endcase
  end

  // Bit 0 never needs flipping: only data positions are extracted.
  assign flip[0] = 1'b0;
  for (genvar p = 1; p < CODE_W; p++) begin : g_flip
    assign flip[p] = fix && (syn == 6'(p));
  end

  assign fixed = word_i ^ flip;

  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int POS = data_pos(k);
    assign data_o[k] = fixed[POS];
  end

endmodule

// File: rtl/if_ecc_stage.sv
// Instruction fetch stage with SECDED-protected instruction memory,
// IF/ID register, halt-on-double-error and corrected-error counter.
module if_ecc_stage
  import if_ecc_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CE_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [31:0]         pc_target_i,
  output logic [31:0]         imem_addr_o,
  input  logic [38:0]         imem_rdata_i,
  output logic [31:0]         instr_o,
  output logic [6:0]          op_o,
  output logic [31:0]         pc_o,
  output logic                valid_o,
  output logic                corrected_o,
  output logic                uncorrectable_o,
  output logic [CE_CNT_W-1:0] ce_count_o
);

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  if_id_t              ifid_q, ifid_d;
  logic                unc_q, unc_d;
  logic [CE_CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0]   dec_data;
  logic                dec_corr;
  logic                dec_unc;

  secded_39_32_dec u_dec (
    .word_i          (imem_rdata_i),
    .data_o          (dec_data),
    .corrected_o     (dec_corr),
    .uncorrectable_o (dec_unc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    unc_d   = unc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          flush_i: begin
            pc_d             = pc_target_i;
            ifid_d.valid     = 1'b0;
            ifid_d.corrected = 1'b0;
          end
          !flush_i && stall_i: begin
            pc_d = pc_q;
          end
          !flush_i && !stall_i && dec_unc: begin
            ifid_d.valid     = 1'b0;
            ifid_d.corrected = 1'b0;
            unc_d            = 1'b1;
            state_d          = HALT;
          end
          default: begin
            ifid_d.instr     = dec_data;
            ifid_d.pc        = pc_q;
            ifid_d.valid     = 1'b1;
            ifid_d.corrected = dec_corr;
            pc_d             = pc_q + 32'd4;
            if (dec_corr && !(&cnt_q)) cnt_d = cnt_q + CE_CNT_W'(1);
          end
        endcase
      end
      HALT: begin
        ifid_d.valid     = 1'b0;
        ifid_d.corrected = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ifid_q  <= '{instr: NOP, pc: '0, valid: 1'b0, corrected: 1'b0};
      unc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      unc_q   <= unc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign instr_o         = ifid_q.instr;
  assign op_o            = ifid_q.instr[6:0];
  assign pc_o            = ifid_q.pc;
  assign valid_o         = ifid_q.valid;
  assign corrected_o     = ifid_q.corrected;
  assign uncorrectable_o = unc_q;
  assign ce_count_o      = cnt_q;

endmodule

// File: tb/tb_if_ecc_stage.sv
// Scoreboard bench for if_ecc_stage: driver pushes model expectations,
// monitor pops and compares every cycle at the falling edge.
module tb_if_ecc_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [31:0]   pc_target_i = '0;
  logic [31:0]   imem_addr_o;
  logic [38:0]   imem_rdata_i = '0;
  logic [31:0]   instr_o;
  logic [6:0]    op_o;
  logic [31:0]   pc_o;
  logic          valid_o;
  logic          corrected_o;
  logic          uncorrectable_o;
  logic [CW-1:0] ce_count_o;

  if_ecc_stage #(.RESET_PC(RPC), .CE_CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .pc_target_i     (pc_target_i),
    .imem_addr_o     (imem_addr_o),
    .imem_rdata_i    (imem_rdata_i),
    .instr_o         (instr_o),
    .op_o            (op_o),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
    .corrected_o     (corrected_o),
    .uncorrectable_o (uncorrectable_o),
    .ce_count_o      (ce_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        corr;
    logic        unc;
    int          cnt;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_pc, m_instr, m_pco;
  logic        m_valid, m_corr, m_unc, m_halt;
  int          m_cnt;

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] w;
    int          k;
    logic        b;
    w = '0;
    k = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      b = 1'b0;
      for (int p = 1; p < 39; p++)
        if (((p >> j) & 1) == 1 && (p & (p - 1)) != 0) b = b ^ w[p];
      w[1 << j] = b;
    end
    w[0] = ^w[38:1];
    return w;
  endfunction

  function automatic exp_t cur();
    exp_t e;
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pc    = m_pco;
    e.valid = m_valid;
    e.corr  = m_corr;
    e.unc   = m_unc;
    e.cnt   = m_cnt;
    return e;
  endfunction

  task automatic chk(input string tag, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", tag, nm, act, exp);
    end
  endtask

  task automatic check_rec(input exp_t e, input string tag);
    logic [31:0] eop;
    eop = {25'd0, e.instr[6:0]};
    chk(tag, "addr",  imem_addr_o, e.addr);
    chk(tag, "instr", instr_o, e.instr);
    chk(tag, "op",    32'(op_o), eop);
    chk(tag, "pc",    pc_o, e.pc);
    chk(tag, "valid", 32'(valid_o), 32'(e.valid));
    chk(tag, "corr",  32'(corrected_o), 32'(e.corr));
    chk(tag, "unc",   32'(uncorrectable_o), 32'(e.unc));
    chk(tag, "cnt",   32'(ce_count_o), 32'(e.cnt));
  endtask

  task automatic model_reset();
    m_pc    = RPC;
    m_instr = 32'h0000_0013;
    m_pco   = '0;
    m_valid = 1'b0;
    m_corr  = 1'b0;
    m_unc   = 1'b0;
    m_halt  = 1'b0;
    m_cnt   = 0;
  endtask

  // One cycle: f1/f2 are flipped code positions, -1 for none.
  task automatic step(input bit st, input bit fl, input logic [31:0] tgt,
                      input logic [31:0] d, input int f1, input int f2);
    logic [38:0] w;
    int          nfl;
    w   = enc(d);
    nfl = 0;
    if (f1 >= 0) begin w = w ^ (39'(1) << f1); nfl++; end
    if (f2 >= 0) begin w = w ^ (39'(1) << f2); nfl++; end
    stall_i      = st;
    flush_i      = fl;
    pc_target_i  = tgt;
    imem_rdata_i = w;
    if (!m_halt) begin
      if (fl) begin
        m_pc    = tgt;
        m_valid = 1'b0;
        m_corr  = 1'b0;
      end else if (!st) begin
        if (nfl >= 2) begin
          m_valid = 1'b0;
          m_corr  = 1'b0;
          m_unc   = 1'b1;
          m_halt  = 1'b1;
        end else begin
          m_instr = d;
          m_pco   = m_pc;
          m_valid = 1'b1;
          m_corr  = (nfl == 1);
          if (nfl == 1 && m_cnt < (1 << CW) - 1) m_cnt++;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    sbq.push_back(cur());
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_rec(cur(), tag);
    @(posedge clk);
    sbq.push_back(cur());
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check_rec(e, "mon");
      end
    end
  end

  initial begin : driver
    logic [31:0] d, tgt;
    int          r, e, p1, p2;
    localparam logic [31:0] W0 = 32'h0050_0093;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset("rst0");

    step(0, 0, 0, W0, -1, -1);
    step(0, 0, 0, W0, 3, -1);
    step(0, 0, 0, W0, 0, -1);
    repeat (3) step(1, 0, 0, $urandom(), 3, 5);
    step(1, 1, 32'hFFFF_FFFC, $urandom(), -1, -1);
    step(0, 0, 0, 32'h1234_5673, -1, -1);
    step(1, 1, 32'h0000_0100, W0, 3, 5);
    step(0, 0, 0, W0, 38, -1);

    for (int rd = 0; rd < 8; rd++) begin
      for (int i = 0; i < 40; i++) begin
        r   = $urandom_range(0, 99);
        e   = $urandom_range(0, 99);
        d   = $urandom();
        tgt = $urandom() & 32'hFFFF_FFFC;
        p1  = -1;
        p2  = -1;
        if (e >= 55) p1 = $urandom_range(0, 38);
        if (e >= 95) begin
          p2 = $urandom_range(0, 37);
          if (p2 >= p1) p2++;
        end
        step(r < 15, r >= 15 && r < 25, tgt, d, p1, p2);
      end
      do_reset("rst_rnd");
    end

    for (int i = 0; i < 17; i++)
      step(0, 0, 0, $urandom(), $urandom_range(0, 38), -1);
    step(0, 0, 0, W0, 3, 5);
    repeat (3) step(0, 1, 32'h0000_0100, W0, -1, -1);
    step(1, 1, 32'h0000_0100, W0, -1, -1);
    do_reset("rst_halt");
    repeat (3) step(0, 0, 0, $urandom(), -1, -1);

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
